// File: rtl/scheduler_pkg.sv
// Shared sizing, default timing and FSM state encoding for the digitize scheduler.
package scheduler_pkg;

    localparam int NUM_HOLD    = 4;
    localparam int IDX_W       = $clog2(NUM_HOLD);
    localparam int DIG_MIN_DEF = 4;
    localparam int TIMEOUT_DEF = 16'hFFFF;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIG  = 2'd1,
        ST_READ = 2'd2,
        ST_CLR  = 2'd3
    } state_t;

endpackage

// File: rtl/hold_order_fifo.sv
// Captures rising hold bits into a pending mask and moves them, lowest index first,
// into an oldest-first index FIFO popped by the scheduler FSM.
module hold_order_fifo
    import scheduler_pkg::*;
(
    input  logic                clk33_i,
    input  logic                nrst_i,
    input  logic [NUM_HOLD-1:0] hold_i,
    input  logic [NUM_HOLD-1:0] active_i,
    input  logic                pop_i,
    output logic                empty_o,
    output logic [IDX_W-1:0]    head_o
);

    logic [NUM_HOLD-1:0] hold_q;
    logic [NUM_HOLD-1:0] pending;
    logic [NUM_HOLD-1:0] queued;
    logic [IDX_W-1:0]    mem [NUM_HOLD];
    logic [IDX_W-1:0]    wr_ptr;
    logic [IDX_W-1:0]    rd_ptr;
    logic [IDX_W:0]      count;

    logic                push;
    logic [IDX_W-1:0]    push_idx;
    logic                pop_fire;
    logic [NUM_HOLD-1:0] push_mask;
    logic [NUM_HOLD-1:0] pop_mask;
    logic [NUM_HOLD-1:0] rise;

    always_comb begin
        push     = 1'b0;
        push_idx = '0;
        // descending scan so the lowest pending index wins
        for (int k = NUM_HOLD - 1; k >= 0; k--) begin
            if (pending[k]) begin
                push     = 1'b1;
                push_idx = IDX_W'(k);
            end
        end
    end

    assign pop_fire  = pop_i && (count != '0);
    assign push_mask = push ? (NUM_HOLD'(1) << push_idx) : '0;
    assign pop_mask  = pop_fire ? (NUM_HOLD'(1) << mem[rd_ptr]) : '0;
    // a bit that is already pending, queued or being served is not captured again
    assign rise      = hold_i & ~hold_q & ~(pending | queued | active_i);
    assign empty_o   = (count == '0);
    assign head_o    = mem[rd_ptr];

    always_ff @(posedge clk33_i or negedge nrst_i) begin
        if (!nrst_i) begin
            hold_q  <= '0;
            pending <= '0;
            queued  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            hold_q  <= hold_i;
            pending <= (pending & ~push_mask) | rise;
            queued  <= (queued | push_mask) & ~pop_mask;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk33_i) begin
        if (push) begin
            mem[wr_ptr] <= push_idx;
        end
    end

endmodule

// File: rtl/digitize_scheduler.sv
// Serves held analog buffers oldest-first: digitize, wait for LAB and MESS, then release.
// state | meaning
// IDLE  | waiting for a queued buffer
// DIG   | digitize asserted, watchdog running
// READ  | event_valid high, waiting for MESS readout_done
// CLR   | one-cycle release pulse, event number advances on exit
module digitize_scheduler
    import scheduler_pkg::*;
#(
    parameter int DIG_MIN = DIG_MIN_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                clk33_i,
    input  logic                nrst_i,
    input  logic [NUM_HOLD-1:0] hold_i,
    input  logic [NUM_HOLD-1:0] lab_done_i,
    input  logic                readout_done_i,
    output logic [NUM_HOLD-1:0] digitize_o,
    output logic                clear_o,
    output logic [IDX_W-1:0]    clear_buffer_o,
    output logic                event_valid_o,
    output logic [31:0]         event_num_o,
    output logic [IDX_W-1:0]    cur_buf_o,
    output logic                busy_o,
    output logic                timeout_o
);

    state_t              state;
    logic [CNT_W-1:0]    wd_cnt;
    logic                fifo_empty;
    logic [IDX_W-1:0]    fifo_head;
    logic                fifo_pop;
    logic [NUM_HOLD-1:0] active_mask;

    assign fifo_pop    = (state == ST_IDLE) && !fifo_empty;
    assign active_mask = busy_o ? (NUM_HOLD'(1) << cur_buf_o) : '0;

    hold_order_fifo u_fifo (
        .clk33_i  (clk33_i),
        .nrst_i   (nrst_i),
        .hold_i   (hold_i),
        .active_i (active_mask),
        .pop_i    (fifo_pop),
        .empty_o  (fifo_empty),
        .head_o   (fifo_head)
    );

    always_ff @(posedge clk33_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state          <= ST_IDLE;
            wd_cnt         <= '0;
            digitize_o     <= '0;
            clear_o        <= 1'b0;
            clear_buffer_o <= '0;
            event_valid_o  <= 1'b0;
            event_num_o    <= '0;
            cur_buf_o      <= '0;
            busy_o         <= 1'b0;
            timeout_o      <= 1'b0;
        end else begin
            clear_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur_buf_o  <= fifo_head;
                        digitize_o <= NUM_HOLD'(1) << fifo_head;
                        wd_cnt     <= '0;
                        busy_o     <= 1'b1;
                        state      <= ST_DIG;
                    end
                end
                ST_DIG: begin
                    // wd_cnt holds (cycles spent in DIG - 1) during the current cycle
                    if (lab_done_i[cur_buf_o] && (wd_cnt >= CNT_W'(DIG_MIN - 1))) begin
                        digitize_o    <= '0;
                        event_valid_o <= 1'b1;
                        state         <= ST_READ;
                    end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
                        digitize_o     <= '0;
                        timeout_o      <= 1'b1;
                        clear_o        <= 1'b1;
                        clear_buffer_o <= cur_buf_o;
                        state          <= ST_CLR;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_READ: begin
                    if (readout_done_i) begin
                        event_valid_o  <= 1'b0;
                        clear_o        <= 1'b1;
                        clear_buffer_o <= cur_buf_o;
                        state          <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    event_num_o <= event_num_o + 32'd1;
                    busy_o      <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digitize_scheduler.sv
// Scoreboard bench: stimulus queues the expected service order, a monitor checks each event.
module tb_digitize_scheduler;

    localparam int NH   = 4;
    localparam int TMO  = 20;
    localparam int DMIN = 4;

    logic        clk33 = 1'b0;
    logic        nrst;
    logic [3:0]  hold;
    logic [3:0]  lab_done;
    logic        rd_a, rd_b, rd_c;
    logic        readout_done;
    logic [3:0]  digitize_o;
    logic        clear_o;
    logic [1:0]  clear_buffer_o;
    logic        event_valid_o;
    logic [31:0] event_num_o;
    logic [1:0]  cur_buf_o;
    logic        busy_o;
    logic        timeout_o;

    assign readout_done = rd_a | rd_b | rd_c;

    always #15 clk33 = ~clk33;

    digitize_scheduler #(.DIG_MIN(DMIN), .TIMEOUT(TMO)) dut (
        .clk33_i        (clk33),
        .nrst_i         (nrst),
        .hold_i         (hold),
        .lab_done_i     (lab_done),
        .readout_done_i (readout_done),
        .digitize_o     (digitize_o),
        .clear_o        (clear_o),
        .clear_buffer_o (clear_buffer_o),
        .event_valid_o  (event_valid_o),
        .event_num_o    (event_num_o),
        .cur_buf_o      (cur_buf_o),
        .busy_o         (busy_o),
        .timeout_o      (timeout_o)
    );

    typedef struct {
        int dur;
        bit tmo;
    } resp_t;

    int    q_order[$];
    resp_t q_resp[$];
    int    checks = 0;
    int    errors = 0;
    int    model_evnum = 0;
    bit    model_tmo = 1'b0;
    int    events_expected = 0;
    int    events_done = 0;
    bit    mon_en = 1'b0;
    bit    rd_en = 1'b0;
    int    forced_lat = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic summary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic mstep();
        @(posedge clk33);
        #1;
    endtask

    // LAB model: answers the digitize request after a randomly chosen latency (0 = never)
    initial begin : lab_responder
        int         lat;
        logic [3:0] d;
        resp_t      r;
        lab_done = '0;
        rd_c     = 1'b0;
        forever begin
            @(negedge clk33);
            if (digitize_o != '0) begin
                d = digitize_o;
                if (forced_lat >= 0) lat = forced_lat;
                else lat = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 16));
                r.tmo = (lat == 0);
                r.dur = (lat == 0) ? TMO : ((lat < DMIN) ? DMIN : lat);
                q_resp.push_back(r);
                for (int c = 1; c <= TMO + 5 && digitize_o != '0; c++) begin
                    if (lat != 0 && c >= lat) lab_done = d;
                    rd_c = rd_en && ($urandom_range(0, 5) == 0);
                    @(negedge clk33);
                end
                lab_done = '0;
                rd_c     = 1'b0;
            end
        end
    end

    // MESS model: one-cycle readout_done pulse some cycles after event_valid
    initial begin : mess_responder
        int w;
        rd_a = 1'b0;
        forever begin
            @(negedge clk33);
            if (event_valid_o && rd_en) begin
                w = $urandom_range(0, 6);
                repeat (w) @(negedge clk33);
                rd_a = 1'b1;
                @(negedge clk33);
                rd_a = 1'b0;
                for (int c = 0; c < 4 && event_valid_o; c++) @(negedge clk33);
            end
        end
    end

    task automatic handle_event();
        int         idx, dur, c;
        resp_t      r;
        logic [3:0] d;
        bit         bad_ev;
        d = digitize_o;
        if (q_order.size() == 0) begin
            chk("unexpected_digitize", {28'd0, d}, 32'd0);
            for (int k = 0; k < 100 && digitize_o != '0; k++) mstep();
            return;
        end
        idx = q_order.pop_front();
        chk("digitize_onehot", {28'd0, d}, 32'd1 << idx);
        chk("cur_buf", {30'd0, cur_buf_o}, idx);
        chk("busy_in_dig", {31'd0, busy_o}, 32'd1);
        chk("evnum_in_dig", event_num_o, model_evnum);
        dur = 1;
        while (digitize_o != '0 && dur < 200) begin
            mstep();
            if (digitize_o != '0) dur++;
        end
        if (q_resp.size() == 0) begin
            chk("lab_response_missing", 32'd0, 32'd1);
            return;
        end
        r = q_resp.pop_front();
        chk("digitize_cycles", dur, r.dur);
        if (r.tmo) begin
            model_tmo = 1'b1;
            chk("tmo_clear", {31'd0, clear_o}, 32'd1);
            chk("tmo_no_event_valid", {31'd0, event_valid_o}, 32'd0);
            chk("tmo_flag", {31'd0, timeout_o}, 32'd1);
            chk("tmo_clear_buffer", {30'd0, clear_buffer_o}, idx);
        end else begin
            chk("event_valid_rise", {31'd0, event_valid_o}, 32'd1);
            chk("evnum_at_valid", event_num_o, model_evnum);
            chk("no_early_clear", {31'd0, clear_o}, 32'd0);
            c = 0;
            bad_ev = 1'b0;
            while (clear_o !== 1'b1 && c < 300) begin
                if (event_valid_o !== 1'b1 || event_num_o !== model_evnum) bad_ev = 1'b1;
                mstep();
                c++;
            end
            chk("event_valid_held", {31'd0, bad_ev}, 32'd0);
            chk("clear_after_read", {31'd0, clear_o}, 32'd1);
            chk("readout_to_clear_1cyc", {31'd0, readout_done}, 32'd1);
            chk("clear_buffer", {30'd0, clear_buffer_o}, idx);
            chk("valid_drop_at_clear", {31'd0, event_valid_o}, 32'd0);
            chk("timeout_sticky", {31'd0, timeout_o}, {31'd0, model_tmo});
        end
        mstep();
        model_evnum++;
        chk("evnum_after_clear", event_num_o, model_evnum);
        chk("clear_one_cycle", {31'd0, clear_o}, 32'd0);
        chk("idle_after_clear", {31'd0, busy_o}, 32'd0);
        chk("gap_after_clear", {28'd0, digitize_o}, 32'd0);
        events_done++;
    endtask

    initial begin : monitor
        forever begin
            mstep();
            if (mon_en && digitize_o != '0) handle_event();
        end
    end

    task automatic raise(input logic [3:0] m);
        for (int k = 0; k < NH; k++) begin
            if (m[k]) begin
                q_order.push_back(k);
                events_expected++;
            end
        end
        hold = hold | m;
    endtask

    task automatic finish_round(input int idle_cycles);
        int  c;
        bit  bad;
        c = 0;
        while (events_done != events_expected && c < 4000) begin
            @(negedge clk33);
            c++;
        end
        if (events_done != events_expected) begin
            chk("round_complete", events_done, events_expected);
            summary();
        end
        bad = 1'b0;
        repeat (idle_cycles) begin
            @(negedge clk33);
            if (busy_o || clear_o) bad = 1'b1;
        end
        chk("idle_no_requeue", {31'd0, bad}, 32'd0);
        hold = '0;
        repeat (3) @(negedge clk33);
    endtask

    initial begin : global_watchdog
        #(30 * 60000);
        chk("global_time_limit", 32'd0, 32'd1);
        summary();
    end

    initial begin : stimulus
        logic [3:0] m1, m2;
        bit         bad;
        int         c;
        nrst = 1'b0;
        hold = '0;
        rd_b = 1'b0;
        repeat (3) @(negedge clk33);
        chk("rst_digitize", {28'd0, digitize_o}, 32'd0);
        chk("rst_clear", {31'd0, clear_o}, 32'd0);
        chk("rst_clear_buffer", {30'd0, clear_buffer_o}, 32'd0);
        chk("rst_event_valid", {31'd0, event_valid_o}, 32'd0);
        chk("rst_event_num", event_num_o, 32'd0);
        chk("rst_cur_buf", {30'd0, cur_buf_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
        nrst = 1'b1;
        repeat (2) @(negedge clk33);

        // reset asserted while an event sits in READ
        forced_lat = 3;
        hold = 4'b0100;
        c = 0;
        while (!event_valid_o && c < 60) begin
            @(negedge clk33);
            c++;
        end
        chk("pre_reset_event_valid", {31'd0, event_valid_o}, 32'd1);
        nrst = 1'b0;
        #1;
        chk("midrst_digitize", {28'd0, digitize_o}, 32'd0);
        chk("midrst_event_valid", {31'd0, event_valid_o}, 32'd0);
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_clear", {31'd0, clear_o}, 32'd0);
        hold = '0;
        repeat (2) @(negedge clk33);
        nrst = 1'b1;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk33);
            if (clear_o || busy_o || digitize_o != '0) bad = 1'b1;
        end
        chk("post_reset_quiet", {31'd0, bad}, 32'd0);
        chk("post_reset_evnum", event_num_o, 32'd0);
        q_resp.delete();

        mon_en = 1'b1;
        rd_en  = 1'b1;

        forced_lat = 10;
        raise(4'b0001);
        finish_round(2);

        forced_lat = 5;
        raise(4'b1010);
        finish_round(2);

        forced_lat = 1;
        raise(4'b0001);
        finish_round(2);

        forced_lat = 0;
        raise(4'b0010);
        finish_round(2);

        // spurious readout while idle, then hold glitches on the active buffer
        rd_b = 1'b1;
        @(negedge clk33);
        rd_b = 1'b0;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk33);
            if (busy_o || clear_o || event_valid_o) bad = 1'b1;
        end
        chk("spurious_readout_idle", {31'd0, bad}, 32'd0);
        forced_lat = 12;
        raise(4'b0001);
        c = 0;
        while (digitize_o == '0 && c < 20) begin
            @(negedge clk33);
            c++;
        end
        @(negedge clk33);
        hold = 4'b0000;
        @(negedge clk33);
        hold = 4'b0001;
        @(negedge clk33);
        hold = 4'b0000;
        @(negedge clk33);
        hold = 4'b0001;
        finish_round(30);

        forced_lat = -1;
        for (int r = 0; r < 30; r++) begin
            m1 = 4'($urandom_range(1, 15));
            raise(m1);
            if ($urandom_range(0, 1) == 1 && m1 != 4'hF) begin
                repeat ($urandom_range(5, 12)) @(negedge clk33);
                m2 = ~m1 & 4'($urandom_range(1, 15));
                if (m2 != '0) raise(m2);
            end
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(2, 20)) @(negedge clk33);
                hold = '0;
            end
            finish_round(3);
        end

        repeat (10) @(negedge clk33);
        chk("order_queue_drained", q_order.size(), 32'd0);
        chk("lab_queue_drained", q_resp.size(), 32'd0);
        chk("final_timeout_flag", {31'd0, timeout_o}, {31'd0, model_tmo});
        summary();
    end

endmodule
